// File: rtl/ctrl_stage_pipe_if.sv
// Control-word pipeline bundle: decode-side inputs plus per-stage registered outputs.
// Latency: none, this is wiring only.
// Backpressure: in_ready reflects stall as seen from decode; there is no output handshake.
//
// master: the decode/hazard side. It drives in_data, in_valid, stall and flush.
// slave : the pipeline. It drives in_ready, stage_data, stage_valid, busy and bubble_cnt.
interface ctrl_stage_pipe_if #(
  parameter int WIDTH  = 20,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
);
  logic [WIDTH-1:0]        in_data;
  logic                    in_valid;
  logic [STAGES:0]         stall;
  logic [STAGES-1:0]       flush;
  logic                    in_ready;
  logic [STAGES*WIDTH-1:0] stage_data;
  logic [STAGES-1:0]       stage_valid;
  logic                    busy;
  logic [CNT_W-1:0]        bubble_cnt;

  modport master (
    output in_data, in_valid, stall, flush,
    input  in_ready, stage_data, stage_valid, busy, bubble_cnt
  );

  modport slave (
    input  in_data, in_valid, stall, flush,
    output in_ready, stage_data, stage_valid, busy, bubble_cnt
  );
endinterface

// File: rtl/ctrl_stage_pipe.sv
// Control-word pipeline: carries decoded control from decode through STAGES registers with stall/flush/bubbles.
// Latency: a word accepted at decode on edge n is visible in stage k after edge n+k.
// Backpressure: a stall at any stage freezes it and everything upstream; in_ready = no effective stall at decode.
//
// Ports: clk, rst (async, active-high) are plain ports; everything else is carried on
// pipe (slave modport). stage k owns stage_data[k*WIDTH-1 -: WIDTH] and stage_valid[k-1].
module ctrl_stage_pipe #(
  parameter int WIDTH  = 20,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  ctrl_stage_pipe_if.slave pipe
);

  // sEff[j]: stage j is frozen, either by its own stall or by any stall further downstream.
  logic [STAGES:0]   sEff;
  logic [STAGES-1:0] validQ;
  logic [WIDTH-1:0]  dataQ [1:STAGES];

  // Upstream source for stage k is index k-1; index 0 is the decode stage.
  logic [STAGES-1:0] upValid;
  logic [WIDTH-1:0]  upData [STAGES];

  // bubbleHit[k-1]: stage k advances while its upstream is frozen and it is not being flushed.
  logic [STAGES-1:0] bubbleHit;
  logic [CNT_W-1:0]  bubbleCnt;

  genvar j, k;

  generate
    for (j = 0; j <= STAGES; j++) begin : g_seff
      assign sEff[j] = |pipe.stall[STAGES:j];
    end
  endgenerate

  assign upValid[0] = pipe.in_valid;
  assign upData[0]  = pipe.in_data;

  generate
    for (k = 1; k < STAGES; k++) begin : g_up
      assign upValid[k] = validQ[k-1];
      assign upData[k]  = dataQ[k];
    end
  endgenerate

  generate
    for (k = 1; k <= STAGES; k++) begin : g_stage
      assign bubbleHit[k-1] = ~pipe.flush[k-1] & sEff[k-1] & ~sEff[k];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          validQ[k-1] <= 1'b0;
          dataQ[k]    <= '0;
        end else if (pipe.flush[k-1]) begin
          validQ[k-1] <= 1'b0;
          dataQ[k]    <= '0;
        end else if (!sEff[k]) begin
          if (sEff[k-1]) begin
            // Upstream frozen, this stage moves on: fill with a bubble.
            validQ[k-1] <= 1'b0;
            dataQ[k]    <= '0;
          end else begin
            // Invalid words are zeroed so downstream enables never see stale bits.
            validQ[k-1] <= upValid[k-1];
            dataQ[k]    <= upValid[k-1] ? upData[k-1] : '0;
          end
        end
      end

      assign pipe.stage_data[k*WIDTH-1 -: WIDTH] = dataQ[k];
    end
  endgenerate

  // One count per edge regardless of how many stages bubble; saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubbleCnt <= '0;
    end else if ((|bubbleHit) && (bubbleCnt != {CNT_W{1'b1}})) begin
      bubbleCnt <= bubbleCnt + CNT_W'(1);
    end
  end

  assign pipe.in_ready    = ~sEff[0];
  assign pipe.stage_valid = validQ;
  assign pipe.busy        = |validQ;
  assign pipe.bubble_cnt  = bubbleCnt;

endmodule

// File: tb/tb_ctrl_stage_pipe.sv
// Directed bench for ctrl_stage_pipe: default 3-stage build, a 1-stage build, and a 2-bit counter build.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: in_ready is checked combinationally before the stalled edge.
module tb_ctrl_stage_pipe;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ctrl_stage_pipe_if #(.WIDTH(20), .STAGES(3), .CNT_W(16)) bus  ();
  ctrl_stage_pipe_if #(.WIDTH(4),  .STAGES(1), .CNT_W(16)) bus1 ();
  ctrl_stage_pipe_if #(.WIDTH(8),  .STAGES(3), .CNT_W(2))  bus2 ();

  ctrl_stage_pipe #(.WIDTH(20), .STAGES(3), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .pipe(bus));
  ctrl_stage_pipe #(.WIDTH(4),  .STAGES(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .pipe(bus1));
  ctrl_stage_pipe #(.WIDTH(8),  .STAGES(3), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .pipe(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check all three stage words, the valid vector and the bubble count of the main build.
  task automatic exp3(input string tag, input logic [19:0] d1, input logic [19:0] d2,
                      input logic [19:0] d3, input logic [2:0] v, input logic [15:0] c);
    chk({tag, ".s1"},  64'(bus.stage_data[19:0]),  64'(d1));
    chk({tag, ".s2"},  64'(bus.stage_data[39:20]), 64'(d2));
    chk({tag, ".s3"},  64'(bus.stage_data[59:40]), 64'(d3));
    chk({tag, ".vld"}, 64'(bus.stage_valid),       64'(v));
    chk({tag, ".cnt"}, 64'(bus.bubble_cnt),        64'(c));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_data  = '0; bus.in_valid  = 1'b0; bus.stall  = '0; bus.flush  = '0;
    bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.stall = '0; bus1.flush = '0;
    bus2.in_data = '0; bus2.in_valid = 1'b0; bus2.stall = '0; bus2.flush = '0;
    #2;
    exp3("rst", 20'h0, 20'h0, 20'h0, 3'b000, 16'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.rdy",  64'(bus.in_ready), 64'd1);
    #1 rst = 1'b0;

    // Single-stage build: decode is the only upstream stage.
    bus1.in_valid = 1'b1; bus1.in_data = 4'h5;
    step();
    chk("one.load", 64'(bus1.stage_data), 64'h5);
    chk("one.vld",  64'(bus1.stage_valid), 64'd1);
    bus1.stall = 2'b01; bus1.in_data = 4'h6;
    #1 chk("one.rdy", 64'(bus1.in_ready), 64'd0);
    step();
    chk("one.bub",     64'(bus1.stage_data), 64'h0);
    chk("one.bubvld",  64'(bus1.stage_valid), 64'd0);
    chk("one.bubcnt",  64'(bus1.bubble_cnt), 64'd1);
    bus1.stall = 2'b00;
    step();
    chk("one.adv", 64'(bus1.stage_data), 64'h6);
    bus1.stall = 2'b10; bus1.in_data = 4'h7;
    step();
    chk("one.hold",    64'(bus1.stage_data), 64'h6);
    chk("one.holdcnt", 64'(bus1.bubble_cnt), 64'd1);
    bus1.flush = 1'b1;
    step();
    chk("one.flush",    64'(bus1.stage_valid), 64'd0);
    chk("one.flushdat", 64'(bus1.stage_data), 64'h0);
    chk("one.flushcnt", 64'(bus1.bubble_cnt), 64'd1);
    bus1.in_valid = 1'b0; bus1.stall = '0; bus1.flush = '0;

    // Saturating 2-bit counter: a decode stall bubbles stage 1 every edge.
    bus2.in_valid = 1'b1; bus2.in_data = 8'hA5; bus2.stall = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat.%0d", i), 64'(bus2.bubble_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    bus2.stall = '0;

    // Main build idle so far: nothing valid, no bubbles.
    exp3("idle", 20'h0, 20'h0, 20'h0, 3'b000, 16'd0);

    // Streaming.
    bus.in_valid = 1'b1;
    bus.in_data = 20'd1; step();
    bus.in_data = 20'd2; step();
    bus.in_data = 20'd3; step();
    exp3("str3", 20'd3, 20'd2, 20'd1, 3'b111, 16'd0);
    bus.in_data = 20'd4; step();
    chk("str4.s3", 64'(bus.stage_data[59:40]), 64'd2);
    bus.in_data = 20'd5; step();
    chk("str5.s3", 64'(bus.stage_data[59:40]), 64'd3);
    bus.in_data = 20'd6; step();
    exp3("str6", 20'd6, 20'd5, 20'd4, 3'b111, 16'd0);
    chk("str.busy", 64'(bus.busy), 64'd1);

    // Load-use stall: A=7 in decode, B=6 in stage 1.
    bus.in_data = 20'd7; bus.stall = 4'b0001;
    #1 chk("lu.rdy", 64'(bus.in_ready), 64'd0);
    step();
    exp3("lu1", 20'd0, 20'd6, 20'd5, 3'b110, 16'd1);
    bus.stall = 4'b0000;
    #1 chk("lu.rdy2", 64'(bus.in_ready), 64'd1);
    step();
    exp3("lu2", 20'd7, 20'd0, 20'd6, 3'b101, 16'd1);

    // Refill to 7/6/5 in stages 1/2/3, then stall stage 2 for two edges.
    bus.in_data = 20'd5; step();
    bus.in_data = 20'd6; step();
    bus.in_data = 20'd7; step();
    exp3("ds0", 20'd7, 20'd6, 20'd5, 3'b111, 16'd1);
    bus.in_data = 20'd8; bus.stall = 4'b0100;
    #1 chk("ds.rdy", 64'(bus.in_ready), 64'd0);
    step();
    exp3("ds1", 20'd7, 20'd6, 20'd0, 3'b011, 16'd2);
    step();
    exp3("ds2", 20'd7, 20'd6, 20'd0, 3'b011, 16'd3);
    bus.stall = 4'b0000;
    step();
    exp3("ds3", 20'd8, 20'd7, 20'd6, 3'b111, 16'd3);

    // Flush beats stall on stage 1; stage 2 bubbles; stage 3 advances.
    bus.in_data = 20'd9; step();
    bus.stall = 4'b0010; bus.flush = 3'b001;
    step();
    exp3("fs", 20'd0, 20'd0, 20'd8, 3'b100, 16'd4);
    bus.stall = '0; bus.flush = '0;

    // Flush stage 1 while stage 2 advances: stage 2 still gets the old word; no count.
    bus.in_data = 20'd10; step();
    bus.in_data = 20'd11; step();
    exp3("fa0", 20'd11, 20'd10, 20'd0, 3'b011, 16'd4);
    bus.in_data = 20'd12; bus.flush = 3'b001;
    step();
    exp3("fa1", 20'd0, 20'd11, 20'd10, 3'b110, 16'd4);
    bus.flush = '0;

    // All stalls high: everything holds, no count.
    bus.stall = 4'b1111; bus.in_data = 20'd13;
    step();
    exp3("all", 20'd0, 20'd11, 20'd10, 3'b110, 16'd4);
    bus.stall = '0;

    // Flush every stage at once.
    step();
    exp3("fl0", 20'd13, 20'd0, 20'd11, 3'b101, 16'd4);
    bus.flush = 3'b111;
    step();
    exp3("flall", 20'd0, 20'd0, 20'd0, 3'b000, 16'd4);
    chk("flall.busy", 64'(bus.busy), 64'd0);
    bus.flush = '0;

    // Async reset between edges while full and stalled.
    bus.in_data = 20'd1; step();
    bus.in_data = 20'd2; step();
    bus.in_data = 20'd3; step();
    chk("ar.full", 64'(bus.stage_valid), 64'b111);
    bus.stall = 4'b0100;
    #3 rst = 1'b1;
    #1;
    exp3("ar", 20'h0, 20'h0, 20'h0, 3'b000, 16'd0);
    chk("ar.busy", 64'(bus.busy), 64'd0);
    chk("ar.sat",  64'(bus2.bubble_cnt), 64'd0);
    #1 rst = 1'b0;
    bus.stall = '0; bus.in_data = 20'd20;
    step();
    exp3("ar.post", 20'd20, 20'd0, 20'd0, 3'b001, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_stage_pipe.md
Name: ctrl_stage_pipe

Overview:
- Parametrised control-word pipeline: carries a decoded control bundle from the decode stage through STAGES downstream pipeline registers (default 3: E, M, W).
- Every stage has stall, flush, valid tracking and automatic bubble insertion, not only the first downstream stage.
- Sits between the main/ALU decoders and the datapath; the hazard unit drives it.
- Replaces hand-instantiated per-stage flops with one consistent stall/flush model.

Parameters:
- WIDTH, 20, bits in one control word.
- STAGES, 3, number of downstream pipeline registers (minimum 1).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_data  input  WIDTH  control word from decode (stage 0).
- in_valid  input  1  decode stage holds a real instruction.
- stall  input  STAGES+1  stall request per stage; bit 0 is decode, bit k is stage k.
- flush  input  STAGES  flush request; bit k-1 clears stage k.
- in_ready  output  1  decode may advance this cycle.
- stage_data  output  STAGES*WIDTH  registered word per stage; stage k occupies bits [k*WIDTH-1:(k-1)*WIDTH].
- stage_valid  output  STAGES  valid bit per stage.
- busy  output  1  OR of stage_valid.
- bubble_cnt  output  CNT_W  number of bubbles inserted since reset.

Behaviour:
- Reset: all stage_data = 0, stage_valid = 0, bubble_cnt = 0, asynchronously and immediately. in_ready and busy are combinational: in_ready = 1 when stall = 0; busy = 0.
- Effective stall: s_eff[j] = OR(stall[j..STAGES]).
  - A stalled stage freezes every upstream stage.
  - in_ready = ~s_eff[0].
- Per-stage update at each rising edge, for stage k = 1..STAGES, in priority order:
  1. flush[k-1]: valid_k <= 0 and data_k <= 0. Flush wins over stall.
  2. s_eff[k]: hold valid_k and data_k.
  3. s_eff[k-1] with s_eff[k] = 0: the upstream stage is frozen while this one advances, so insert a bubble (valid_k <= 0, data_k <= 0).
  4. Otherwise: advance.
     - k = 1 loads in_data and in_valid.
     - k > 1 loads data_{k-1} and valid_{k-1}.
- Invalid words always carry zero data: when a stage loads a word with valid = 0, its data register is written 0. Downstream write-enables are therefore never spuriously set.
- Latency: an unstalled word written at decode edge n appears at stage k after edge n+k.
- Last stage: its word is simply overwritten next cycle; there is no output handshake.
- Bubble counter:
  - Increments by 1 on every edge where rule 3 fires at one or more stages. Multiple stages in one cycle still count 1.
  - Saturates at all-ones with no wrap.
  - Flush-induced clears are not counted.
- Simultaneous events:
  - Flush on stage k while stage k+1 advances: stage k+1 receives the old stage-k word. Flush affects only the flushed register.
  - Flush on all stages at once: all stages invalid after the edge.
  - All stall bits high: every register holds and bubble_cnt is unchanged.
- STAGES = 1: rules apply with stage 0 as the only upstream stage.
- Reset asserted mid-stall or mid-flush: immediate clear. After deassertion, the first edge behaves as if from the empty state.
- No combinational path from stage_data to any output other than the registers themselves.

Test Plan:
- Streaming: stall = 0, flush = 0, in_valid = 1, in_data = 1, 2, 3, 4 on successive edges -> stage 3 shows 1 after the 3rd edge, then 2, 3, 4; stage_valid = 3'b111; bubble_cnt = 0.
- Load-use stall:
  - Stimulus: stall = 4'b0001 for one cycle with A in decode and B in stage 1.
  - Response: stage 1 becomes 0 / invalid; decode's A enters stage 1 the following edge; bubble_cnt = 1; in_ready = 0 during the stall cycle.
- Downstream stall:
  - Stimulus: stall = 4'b0100 (stage 2) for 2 cycles with 5, 6, 7 in stages 3, 2, 1.
  - Response: stages 1 and 2 hold 7 and 6; stage 3 gets a bubble on the first edge; bubble_cnt increments once per stalled edge, reaching 2; in_ready = 0.
- Flush vs stall:
  - Stimulus: stall[1] = 1 and flush[0] = 1 together with stage 1 = 9.
  - Response: stage 1 becomes 0 / invalid; stage 2 receives a bubble (stage 1 frozen) and bubble_cnt increments.
- Saturation: CNT_W = 2, force 5 bubble cycles -> bubble_cnt reads 3 and stays 3.
- Async reset: assert rst between clock edges with all stages valid -> outputs clear before the next edge; busy = 0.
